// File: rtl/ex_shifter_pkg.sv
// Shared definitions for the EX-stage iterative shifter: ALU op codes used
// by the shifter and the shifter FSM state encodings.
package ex_shifter_pkg;

   // ALU op codes for the shift family (same values the ALU result mux decodes)
   localparam logic [3:0] ALU_SLL = 4'h1;
   localparam logic [3:0] ALU_SRL = 4'h5;
   localparam logic [3:0] ALU_SRA = 4'hd;

   // Shifter FSM state encodings
   localparam logic [1:0] SH_IDLE = 2'd0;
   localparam logic [1:0] SH_RUN  = 2'd1;
   localparam logic [1:0] SH_DONE = 2'd2;

   // True for the op codes the shifter actually shifts on; anything else
   // passes the operand through unchanged.
   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/ex_shift_step.sv
// One step of the iterative shifter: shifts acc by n (0..STEP) positions
// in the direction and fill given by op. Purely combinational.
module ex_shift_step
   import ex_shifter_pkg::*;
#(
   parameter int STEP = 1
)
(
   input  logic [31:0] acc,
   input  logic [3:0]  n,
   input  logic [3:0]  op,
   output logic [31:0] res
);

   // One pre-shifted candidate per legal distance; a small mux picks one.
   logic [31:0] cand [0:STEP];

   genvar gi;
   generate
      for (gi = 0; gi <= STEP; gi++) begin : g_cand
         assign cand[gi] = (op == ALU_SLL) ? (acc << gi) :
                           (op == ALU_SRL) ? (acc >> gi) :
                           (op == ALU_SRA) ? $unsigned($signed(acc) >>> gi) :
                                             acc;
      end
   endgenerate

   // Select the candidate matching the requested distance (n never exceeds STEP)
   always_comb begin
      res = cand[0];
      for (int i = 1; i <= STEP; i++) begin
         if (n == 4'(i)) begin
            res = cand[i];
         end
      end
   end

endmodule

// File: rtl/ex_shifter.sv
// Multi-cycle iterative shifter for the EX stage. Shifts STEP bit positions
// per RUN cycle and presents the registered result on a one-cycle done
// pulse. STEP must be 1, 2, 4 or 8.
module ex_shifter
   import ex_shifter_pkg::*;
#(
   parameter int STEP = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [3:0]  alu_op,
   input  logic [31:0] a,
   input  logic [4:0]  shamt,
   output logic        busy,
   output logic        done,
   output logic [31:0] shift
);

   localparam logic [4:0] STEP_REM = 5'(STEP);

   logic [1:0]  state_reg, state_next;
   logic [31:0] acc_reg,   acc_next;
   logic [4:0]  rem_reg,   rem_next;
   logic [3:0]  op_reg,    op_next;
   logic [31:0] shift_reg, shift_next;

   logic [3:0]  step_n;
   logic [31:0] step_res;
   logic        last_step;

   // Distance for this cycle is min(STEP, rem); rem never goes below zero
   assign step_n    = (rem_reg < STEP_REM) ? rem_reg[3:0] : 4'(STEP);
   assign last_step = (rem_reg <= STEP_REM);

   ex_shift_step #(
      .STEP (STEP)
   ) u_step (
      .acc (acc_reg),
      .n   (step_n),
      .op  (op_reg),
      .res (step_res)
   );

   // Next-state, datapath and result-capture logic
   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      rem_next   = rem_reg;
      op_next    = op_reg;
      shift_next = shift_reg;

      case (state_reg)
         SH_IDLE: begin
            // flush takes priority and drops a coincident start
            if (start && !flush) begin
               acc_next   = a;
               rem_next   = is_shift_op(alu_op) ? shamt : 5'd0;
               op_next    = alu_op;
               state_next = SH_RUN;
            end
         end

         SH_RUN: begin
            if (flush) begin
               state_next = SH_IDLE;
            end else begin
               acc_next = step_res;
               rem_next = rem_reg - 5'(step_n);
               if (last_step) begin
                  shift_next = step_res;
                  state_next = SH_DONE;
               end
            end
         end

         SH_DONE: begin
            if (flush) begin
               state_next = SH_IDLE;
            end else if (start) begin
               // back-to-back operation, no idle bubble
               acc_next   = a;
               rem_next   = is_shift_op(alu_op) ? shamt : 5'd0;
               op_next    = alu_op;
               state_next = SH_RUN;
            end else begin
               state_next = SH_IDLE;
            end
         end

         default: begin
            state_next = SH_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= SH_IDLE;
         acc_reg   <= 32'h0;
         rem_reg   <= 5'd0;
         op_reg    <= 4'h0;
         shift_reg <= 32'h0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         rem_reg   <= rem_next;
         op_reg    <= op_next;
         shift_reg <= shift_next;
      end
   end

   assign busy  = (state_reg == SH_RUN);
   assign done  = (state_reg == SH_DONE);
   assign shift = shift_reg;

endmodule

// File: tb/tb_ex_shifter.sv
// Self-checking bench for ex_shifter: a STEP=1 and a STEP=4 instance are
// checked against a plain-arithmetic reference for result, latency and busy.
module tb_ex_shifter;
   import ex_shifter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start1, start4, flush;
   logic [3:0]  alu_op;
   logic [31:0] a;
   logic [4:0]  shamt;
   logic        busy1, done1, busy4, done4;
   logic [31:0] shift1, shift4;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_last1 = 32'h0;
   logic [31:0] exp_last4 = 32'h0;

   always #5 clk = ~clk;

   ex_shifter #(.STEP(1)) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .start  (start1),
      .flush  (flush),
      .alu_op (alu_op),
      .a      (a),
      .shamt  (shamt),
      .busy   (busy1),
      .done   (done1),
      .shift  (shift1)
   );

   ex_shifter #(.STEP(4)) u_dut4 (
      .clk    (clk),
      .rst    (rst),
      .start  (start4),
      .flush  (flush),
      .alu_op (alu_op),
      .a      (a),
      .shamt  (shamt),
      .busy   (busy4),
      .done   (done4),
      .shift  (shift4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result: ordinary shift arithmetic, non-shift ops pass through
   function automatic logic [31:0] ref_shift(input logic [3:0] op, input logic [31:0] x, input int s);
      if (op == ALU_SLL) return x << s;
      if (op == ALU_SRL) return x >> s;
      if (op == ALU_SRA) return $unsigned($signed(x) >>> s);
      return x;
   endfunction

   // Reference cycle number of the done pulse (start sampled at end of cycle 0)
   function automatic int ref_done_cycle(input logic [3:0] op, input int s, input int step);
      int eff;
      int k;
      eff = (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) ? s : 0;
      k = (eff + step - 1) / step;
      if (k < 1) k = 1;
      return k + 1;
   endfunction

   // Start one operation on the selected instances and check result, latency, busy cycles
   task automatic run_op(input logic [3:0] op, input logic [31:0] x, input int s,
                         input bit use1, input bit use4);
      int d1 = -1;
      int d4 = -1;
      int b1 = 0;
      int b4 = 0;
      logic [31:0] r1 = 32'h0;
      logic [31:0] r4 = 32'h0;
      @(negedge clk);
      alu_op = op; a = x; shamt = 5'(s);
      start1 = use1; start4 = use4;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start1 = 1'b0; start4 = 1'b0;
         end
         if (busy1) b1++;
         if (busy4) b4++;
         if (done1 && d1 < 0) begin d1 = c; r1 = shift1; end
         if (done4 && d4 < 0) begin d4 = c; r4 = shift4; end
         if ((!use1 || d1 >= 0) && (!use4 || d4 >= 0)) break;
      end
      if (use1) begin
         check("step1_done_cycle", 32'(d1), 32'(ref_done_cycle(op, s, 1)));
         check("step1_result", r1, ref_shift(op, x, s));
         check("step1_busy_cycles", 32'(b1), 32'(ref_done_cycle(op, s, 1) - 1));
         exp_last1 = ref_shift(op, x, s);
      end
      if (use4) begin
         check("step4_done_cycle", 32'(d4), 32'(ref_done_cycle(op, s, 4)));
         check("step4_result", r4, ref_shift(op, x, s));
         check("step4_busy_cycles", 32'(b4), 32'(ref_done_cycle(op, s, 4) - 1));
         exp_last4 = ref_shift(op, x, s);
      end
      $display("op=%h a=%h shamt=%0d step1: done@%0d res=%h  step4: done@%0d res=%h",
               op, x, s, d1, r1, d4, r4);
   endtask

   initial begin
      int cnt;
      bit seen;
      logic [3:0] rop;

      rst = 1'b1; start1 = 1'b0; start4 = 1'b0; flush = 1'b0;
      alu_op = 4'h0; a = 32'h0; shamt = 5'd0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'b0, busy1 | busy4}, 32'h0);
      check("reset_done", {31'b0, done1 | done4}, 32'h0);
      check("reset_shift1", shift1, 32'h0);
      check("reset_shift4", shift4, 32'h0);
      rst = 1'b0;

      // Directed cases from the shift-rule and latency examples
      run_op(ALU_SLL, 32'h0000_0001, 4, 1'b1, 1'b0);
      run_op(ALU_SRA, 32'h8000_0000, 31, 1'b1, 1'b1);
      run_op(ALU_SRL, 32'h8000_0000, 31, 1'b1, 1'b1);
      run_op(ALU_SRL, 32'hF000_0000, 0, 1'b1, 1'b1);
      run_op(ALU_SRL, 32'hF000_0000, 7, 1'b1, 1'b1);
      run_op(4'h0, 32'hDEAD_BEEF, 9, 1'b1, 1'b1);

      // Back-to-back: start held during the DONE cycle
      @(negedge clk);
      alu_op = ALU_SLL; a = 32'h5; shamt = 5'd2; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      cnt = 0;
      while (!done1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check("b2b_first_done", {31'b0, done1}, 32'h1);
      check("b2b_first_cycle", 32'(cnt + 1), 32'(ref_done_cycle(ALU_SLL, 2, 1)));
      check("b2b_first_result", shift1, ref_shift(ALU_SLL, 32'h5, 2));
      alu_op = ALU_SLL; a = 32'h3; shamt = 5'd1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("b2b_no_bubble_busy", {31'b0, busy1}, 32'h1);
      check("b2b_no_bubble_done", {31'b0, done1}, 32'h0);
      @(negedge clk);
      check("b2b_second_done", {31'b0, done1}, 32'h1);
      check("b2b_second_result", shift1, ref_shift(ALU_SLL, 32'h3, 1));
      exp_last1 = ref_shift(ALU_SLL, 32'h3, 1);
      $display("b2b: SLL 5<<2 then SLL 3<<1 result=%h", shift1);

      // Flush in the third RUN cycle of a 10-position shift
      @(negedge clk);
      alu_op = ALU_SLL; a = 32'h1234_5678; shamt = 5'd10; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("flush_busy_before", {31'b0, busy1}, 32'h1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle_busy", {31'b0, busy1}, 32'h0);
      check("flush_idle_done", {31'b0, done1}, 32'h0);
      check("flush_shift_kept", shift1, exp_last1);
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done1) seen = 1'b1;
      end
      check("flush_no_done", {31'b0, seen}, 32'h0);
      $display("flush: SLL shamt=10 aborted in RUN cycle 3, shift=%h", shift1);

      // flush and start together from IDLE: start dropped
      @(negedge clk);
      alu_op = ALU_SRL; a = 32'hFFFF_0000; shamt = 5'd3; start1 = 1'b1; flush = 1'b1;
      @(negedge clk);
      start1 = 1'b0; flush = 1'b0;
      check("flush_start_busy", {31'b0, busy1}, 32'h0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done1 || busy1) seen = 1'b1;
      end
      check("flush_start_no_activity", {31'b0, seen}, 32'h0);
      check("flush_start_shift_kept", shift1, exp_last1);
      $display("flush+start: start dropped, shift=%h", shift1);

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      alu_op = ALU_SLL; a = 32'h0000_00FF; shamt = 5'd20; start1 = 1'b1; start4 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", {31'b0, busy1 | busy4}, 32'h0);
      check("async_rst_done", {31'b0, done1 | done4}, 32'h0);
      check("async_rst_shift1", shift1, 32'h0);
      check("async_rst_shift4", shift4, 32'h0);
      exp_last1 = 32'h0; exp_last4 = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done1 || done4) seen = 1'b1;
      end
      check("async_rst_no_done", {31'b0, seen}, 32'h0);
      $display("async reset mid-RUN: outputs cleared, no done pulse");
      run_op(ALU_SRA, 32'h8765_4321, 13, 1'b1, 1'b1);

      // Randomized operations on both instances
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       rop = ALU_SLL;
            1:       rop = ALU_SRL;
            2:       rop = ALU_SRA;
            default: rop = 4'($urandom_range(0, 15));
         endcase
         run_op(rop, $urandom, int'($urandom_range(0, 31)), 1'b1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
